// File: rtl/bst_pkg.sv
// Shared types for the branch status table update path.
// Status encoding, queue entry layout and the 2-bit update rule.
package bst_pkg;

  typedef logic [1:0] status_t;

  localparam status_t ST_MISS = 2'b00;
  localparam status_t ST_NT   = 2'b01;
  localparam status_t ST_WT   = 2'b10;
  localparam status_t ST_ST   = 2'b11;

  typedef struct packed {
    logic [31:0] pc;
    status_t     status;
    logic [31:0] target;
  } bst_entry_t;

  function automatic status_t bst_next_status(
    input status_t s,
    input logic    taken
  );
    status_t n;
    unique case (s)
      ST_MISS: n = taken ? ST_WT : ST_MISS;
      ST_NT:   n = taken ? ST_WT : ST_NT;
      ST_WT:   n = taken ? ST_ST : ST_NT;
      default: n = taken ? ST_ST : ST_WT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/bst_update_ctrl_fifo.sv
// In-order queue of fetch-time predictions awaiting resolution.
// Flush keeps only the popped head; a same-cycle push is dropped.
module bst_inflight_fifo
  import bst_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  bst_entry_t push_data,
  input  logic       pop,
  input  logic       flush_younger,
  output bst_entry_t head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  bst_entry_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == CNT_FULL);
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Entry storage; contents are don't-care while not counted.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush_younger) begin
      rd_ptr <= wr_ptr;
      cnt    <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/bst_update_ctrl.sv
// Pairs queued predictions with resolved outcomes and drives
// one registered BST write per resolved branch.
module bst_update_ctrl
  import bst_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_valid,
  output logic             pred_ready,
  input  logic [31:0]      pred_pc,
  input  logic [1:0]       pred_status,
  input  logic [31:0]      pred_target,
  input  logic             res_valid,
  input  logic [31:0]      res_pc,
  input  logic             res_taken,
  input  logic [31:0]      res_target,
  input  logic             res_flush,
  output logic             upd_en,
  output logic [31:0]      upd_pc,
  output logic [1:0]       upd_status,
  output logic [31:0]      upd_target,
  output logic             mispredict,
  output logic [CNT_W-1:0] mispred_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  bst_entry_t  push_data;
  bst_entry_t  head;
  logic        full;
  logic        empty;
  logic        flush;
  logic        hit;
  logic        pc_ok;
  status_t     s_eff;
  logic        wr_c;
  logic        mis_c;
  logic        err_c;
  status_t     st_c;
  logic [31:0] tgt_c;

  assign push_data = '{pc: pred_pc,
                       status: pred_status,
                       target: pred_target};
  assign flush      = res_valid & res_flush;
  assign pred_ready = ~full;

  bst_inflight_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk           (clk),
    .rst           (rst),
    .push          (pred_valid),
    .push_data     (push_data),
    .pop           (res_valid),
    .flush_younger (flush),
    .head          (head),
    .full          (full),
    .empty         (empty)
  );

  // Update math: a PC mismatch is treated as a BST miss.
  always_comb begin
    hit   = res_valid & ~empty;
    pc_ok = (head.pc == res_pc);
    s_eff = pc_ok ? head.status : ST_MISS;
    st_c  = bst_next_status(s_eff, res_taken);
    tgt_c = res_taken ? res_target : head.target;
    wr_c  = hit & ((s_eff != ST_MISS) | res_taken);
    mis_c = 1'b0;
    if (hit) begin
      if (s_eff == ST_MISS)
        mis_c = res_taken;
      else
        mis_c = (s_eff[1] != res_taken) |
                (res_taken & (head.target != res_target));
    end
    err_c = res_valid & (empty | ~pc_ok);
  end

  // Registered BST write port and mispredict pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_en     <= 1'b0;
      upd_pc     <= '0;
      upd_status <= '0;
      upd_target <= '0;
      mispredict <= 1'b0;
    end else begin
      upd_en     <= wr_c;
      mispredict <= mis_c;
      if (wr_c) begin
        upd_pc     <= res_pc;
        upd_status <= st_c;
        upd_target <= tgt_c;
      end
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispred_cnt <= '0;
      err_cnt     <= '0;
    end else begin
      if (mis_c && mispred_cnt != '1)
        mispred_cnt <= mispred_cnt + 1'b1;
      if (err_c && err_cnt != '1)
        err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule
